// File: rtl/button_cpu_debug_pkg.sv
// Shared definitions for the debug monitor access block.
//   state_t   : arbitration/access FSM states
//   cmd_t     : debug command captured from the take_* pulses
//   JDO_*     : bit positions of the fields inside the 38-bit jdo payload
//   ctrl_word : layout of the CPU-visible control register
package button_cpu_debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DBG_ACC,
    DBG_CAP,
    CPU_ACC,
    CPU_CAP
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD,    // take_action_ocimem_a: load address/control, then read
    CMD_RDNEXT,  // take_no_action_ocimem_a: read, then increment address
    CMD_WRITE    // take_action_ocimem_b: write, then increment address
  } cmd_t;

  localparam int JDO_W         = 38;
  localparam int JDO_CLR       = 35;
  localparam int JDO_GO        = 34;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;

  function automatic logic [31:0] ctrl_word(input logic go, input logic error,
                                            input logic ready);
    return {29'b0, go, error, ready};
  endfunction

endpackage

// File: rtl/button_cpu_cpu_debug_mon_access_if.sv
// CPU-side Avalon-MM slave bus of the debug monitor.
//   avs_address     : MSB=1 selects the control register, else a RAM word
//   avs_read/write  : request, held by the master until avs_waitrequest=0
//   avs_writedata   : write data
//   avs_readdata    : read data, valid in the cycle avs_waitrequest=0 on a read
//   avs_waitrequest : slave stall
// Handshake: a transfer completes on the rising edge where (avs_read|avs_write)=1
// and avs_waitrequest=0; the master must keep address, data and the request
// stable until that edge and may change them only afterwards.
interface button_cpu_cpu_debug_mon_access_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W:0] avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/button_cpu_cpu_debug_mon_ram.sv
// Single-port DEPTH x 32 synchronous monitor RAM with registered read.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata at addr, 0 = read addr into q (valid next cycle)
//   addr  : word address
//   wdata : write data
//   q     : registered read data; holds its value on writes and idle cycles
// Contents are deliberately not reset.
module button_cpu_cpu_debug_mon_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end
endmodule

// File: rtl/button_cpu_cpu_debug_mon_access.sv
// Debug monitor access: executes debugger commands (take_* pulses with jdo)
// against the monitor RAM and arbitrates a CPU Avalon-MM slave port against
// them, debug first.
//   clk, reset_n            : clock, asynchronous active-low reset
//   jdo, take_*             : debug command payload and 1-clk command pulses
//   avs                     : CPU Avalon-MM slave port (interface)
//   MonDReg                 : last debug read data
//   monitor_ready/error/go  : debugger status and CPU run request
//   dbg_state/pending/mon_areg : FSM state, slot occupancy and address register
module button_cpu_cpu_debug_mon_access
  import button_cpu_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter bit INIT_GO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_no_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  button_cpu_cpu_debug_mon_access_if.slave avs,
  output logic [31:0]          MonDReg,
  output logic                 monitor_ready,
  output logic                 monitor_error,
  output logic                 monitor_go,
  output state_t               dbg_state,
  output logic                 dbg_pending,
  output logic [ADDR_W-1:0]    dbg_mon_areg
);

  state_t            state;
  logic              pending;
  cmd_t              pend_cmd;
  logic [31:0]       pend_wdata;
  cmd_t              cur_cmd;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] mon_areg;
  logic              cpu_done;
  logic [31:0]       readdata_q;

  logic              take_any;
  cmd_t              take_cmd;
  logic              consume;
  logic              overflow;
  logic              cpu_req;
  logic              cpu_ctrl;
  logic              cpu_ctrl_wr;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  // Only the command-relevant jdo fields are consumed.
  logic              jdo_unused;
  assign jdo_unused = ^{jdo[JDO_W-1:JDO_CLR+1], jdo[JDO_WDATA_LSB-1:0]};

  assign take_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    take_cmd = CMD_WRITE;
    if (take_action_ocimem_a)         take_cmd = CMD_LOAD;
    else if (take_no_action_ocimem_a) take_cmd = CMD_RDNEXT;
  end

  // A slot drained by the FSM in the same cycle is free for a new pulse.
  assign consume  = (state == IDLE) && pending;
  assign overflow = take_any && pending && !consume;

  assign cpu_req     = avs.avs_read | avs.avs_write;
  assign cpu_ctrl    = avs.avs_address[ADDR_W];
  assign cpu_ctrl_wr = (state == CPU_ACC) && cpu_ctrl && avs.avs_write;

  assign avs.avs_waitrequest = cpu_req & ~cpu_done;
  assign avs.avs_readdata    = readdata_q;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = mon_areg;
    ram_wdata = cur_wdata;
    case (state)
      DBG_ACC: begin
        ram_en = 1'b1;
        ram_we = (cur_cmd == CMD_WRITE);
      end
      CPU_ACC: begin
        ram_en    = !cpu_ctrl;
        ram_we    = avs.avs_write;
        ram_addr  = avs.avs_address[ADDR_W-1:0];
        ram_wdata = avs.avs_writedata;
      end
      default: ;
    endcase
  end

  button_cpu_cpu_debug_mon_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Later non-blocking assignments below deliberately override earlier ones:
  // debug clear beats CPU set, debug set-go beats CPU clear-go, an overflow
  // error is never masked, and an address load beats the auto-increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      pend_cmd      <= CMD_LOAD;
      pend_wdata    <= '0;
      cur_cmd       <= CMD_LOAD;
      cur_wdata     <= '0;
      mon_areg      <= '0;
      cpu_done      <= 1'b0;
      readdata_q    <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= INIT_GO;
    end else begin
      cpu_done <= 1'b0;

      if (take_any) begin
        pending    <= 1'b1;
        pend_cmd   <= take_cmd;
        pend_wdata <= jdo[JDO_WDATA_LSB +: 32];
      end else if (consume) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state     <= DBG_ACC;
            cur_cmd   <= pend_cmd;
            cur_wdata <= pend_wdata;
          end else if (cpu_req && !cpu_done && !take_any) begin
            // A pulse seen now is pending next cycle, so the CPU waits for it.
            state <= CPU_ACC;
          end
        end
        DBG_ACC: state <= DBG_CAP;
        DBG_CAP: begin
          if (cur_cmd != CMD_WRITE) MonDReg  <= ram_q;
          if (cur_cmd != CMD_LOAD)  mon_areg <= mon_areg + ADDR_W'(1);
          state <= IDLE;
        end
        CPU_ACC: begin
          if (!cpu_ctrl && !avs.avs_write) begin
            state <= CPU_CAP;
          end else begin
            if (cpu_ctrl && !avs.avs_write)
              readdata_q <= ctrl_word(monitor_go, monitor_error, monitor_ready);
            cpu_done <= 1'b1;
            state    <= IDLE;
          end
        end
        CPU_CAP: begin
          readdata_q <= ram_q;
          cpu_done   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (cpu_ctrl_wr) begin
        if (avs.avs_writedata[0]) monitor_ready <= 1'b1;
        if (avs.avs_writedata[1]) monitor_error <= 1'b1;
        if (avs.avs_writedata[2]) monitor_go    <= 1'b0;
      end

      if (take_action_ocimem_a) begin
        mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_CLR]) begin
          monitor_ready <= 1'b0;
          monitor_error <= 1'b0;
        end
        if (jdo[JDO_GO]) monitor_go <= 1'b1;
      end

      if (overflow) monitor_error <= 1'b1;
    end
  end

  assign dbg_state    = state;
  assign dbg_pending  = pending;
  assign dbg_mon_areg = mon_areg;

endmodule

// File: tb/tb_button_cpu_cpu_debug_mon_access.sv
module tb_button_cpu_cpu_debug_mon_access;
  import button_cpu_debug_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] mon_dreg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        monitor_go;
  state_t      dbg_state;
  logic        dbg_pending;
  logic [7:0]  dbg_mon_areg;

  button_cpu_cpu_debug_mon_access_if #(.ADDR_W(8)) avs ();

  button_cpu_cpu_debug_mon_access #(.ADDR_W(8), .INIT_GO(1'b0)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs                     (avs),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go),
    .dbg_state               (dbg_state),
    .dbg_pending             (dbg_pending),
    .dbg_mon_areg            (dbg_mon_areg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- helpers / drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_load(input logic [7:0] addr, input logic clr,
                                           input logic go);
    logic [37:0] v;
    v = '0;
    v[JDO_ADDR_LSB +: 8] = addr;
    v[JDO_CLR] = clr;
    v[JDO_GO]  = go;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[JDO_WDATA_LSB +: 32] = d;
    return v;
  endfunction

  // kind: 0 = action_a, 1 = no_action_a, 2 = action_b. Returns after the capture edge.
  task automatic pulse(input int kind, input logic [37:0] v);
    jdo = v;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    step();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic pulse_wait(input int kind, input logic [37:0] v);
    pulse(kind, v);
    repeat (4) step();
  endtask

  task automatic cpu_xfer(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
    int n;
    n = 0;
    avs.avs_address   = addr;
    avs.avs_write     = wr;
    avs.avs_read      = !wr;
    avs.avs_writedata = wd;
    step();
    while (avs.avs_waitrequest && n < 20) begin
      step();
      n++;
    end
    if (avs.avs_waitrequest) begin
      checks++;
      errors++;
      $error("FAIL cpu_timeout: waitrequest observed 1 expected 0");
    end
    rd = avs.avs_readdata;
    step();
    avs.avs_read  = 1'b0;
    avs.avs_write = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int n;
    jdo = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    avs.avs_address   = '0;
    avs.avs_read      = 1'b0;
    avs.avs_write     = 1'b0;
    avs.avs_writedata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mondreg",   mon_dreg, 32'h0);
    check("rst_readdata",  avs.avs_readdata, 32'h0);
    check("rst_status",    {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
    check("rst_state",     dbg_state, IDLE);
    check("rst_pending",   dbg_pending, 32'h0);
    check("rst_areg",      dbg_mon_areg, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // 1. load + read
    cpu_xfer(1'b1, 9'h010, 32'hDEADBEEF, rd);
    pulse(0, jdo_load(8'h10, 1'b0, 1'b0));
    check("t1_areg",       dbg_mon_areg, 32'h10);
    check("t1_pending",    dbg_pending, 32'h1);
    step();
    step();
    check("t1_dreg_early", mon_dreg, 32'h0);
    step();
    check("t1_dreg",       mon_dreg, 32'hDEADBEEF);
    check("t1_state_idle", dbg_state, IDLE);

    // 2. write burst wrapping past the top of the RAM
    pulse_wait(0, jdo_load(8'hFE, 1'b0, 1'b0));
    pulse_wait(2, jdo_data(32'd1));
    pulse_wait(2, jdo_data(32'd2));
    pulse_wait(2, jdo_data(32'd3));
    check("t2_areg_wrap",  dbg_mon_areg, 32'h01);
    cpu_xfer(1'b0, 9'h0FE, 32'h0, rd);
    check("t2_ram_fe",     rd, 32'd1);
    cpu_xfer(1'b0, 9'h0FF, 32'h0, rd);
    check("t2_ram_ff",     rd, 32'd2);
    cpu_xfer(1'b0, 9'h000, 32'h0, rd);
    check("t2_ram_00",     rd, 32'd3);

    // 3. CPU read and debug pulse in the same IDLE cycle: debug first
    cpu_xfer(1'b1, 9'h020, 32'h12345678, rd);
    avs.avs_address      = 9'h020;
    avs.avs_read         = 1'b1;
    jdo                  = jdo_load(8'hFF, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    check("t3_wait_c0",    avs.avs_waitrequest, 32'h1);
    step();
    check("t3_state_dbg",  dbg_state, DBG_ACC);
    check("t3_wait_c1",    avs.avs_waitrequest, 32'h1);
    step();
    step();
    check("t3_dreg",       mon_dreg, 32'd2);
    check("t3_wait_c3",    avs.avs_waitrequest, 32'h1);
    n = 0;
    while (avs.avs_waitrequest && n < 10) begin
      step();
      n++;
    end
    check("t3_cpu_lat",    n, 32'd3);
    check("t3_readdata",   avs.avs_readdata, 32'h12345678);
    step();
    avs.avs_read = 1'b0;
    step();

    // 4. control register
    cpu_xfer(1'b1, 9'h100, 32'h3, rd);
    check("t4_set_status", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h3);
    cpu_xfer(1'b0, 9'h100, 32'h0, rd);
    check("t4_ctrl_read",  rd, 32'h3);
    avs.avs_address   = 9'h100;
    avs.avs_writedata = 32'h1;
    avs.avs_write     = 1'b1;
    step();
    check("t4_state_cpu",  dbg_state, CPU_ACC);
    jdo                  = jdo_load(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    check("t4_clr_wins",   {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
    check("t4_wait_done",  avs.avs_waitrequest, 32'h0);
    step();
    avs.avs_write = 1'b0;
    repeat (4) step();
    pulse_wait(0, jdo_load(8'h10, 1'b0, 1'b1));
    cpu_xfer(1'b0, 9'h100, 32'h0, rd);
    check("t4_go_read",    rd, 32'h4);
    cpu_xfer(1'b1, 9'h100, 32'h4, rd);
    check("t4_go_clear",   monitor_go, 32'h0);

    // 5. slot overflow: second pulse wins, error raised
    cpu_xfer(1'b1, 9'h031, 32'h11, rd);
    cpu_xfer(1'b1, 9'h032, 32'h22, rd);
    pulse_wait(0, jdo_load(8'h30, 1'b1, 1'b0));
    check("t5_err_clear",  monitor_error, 32'h0);
    pulse(1, 38'h0);
    step();
    check("t5_state_acc",  dbg_state, DBG_ACC);
    jdo                  = jdo_data(32'hAA);
    take_action_ocimem_b = 1'b1;
    step();
    jdo = jdo_data(32'hBB);
    step();
    take_action_ocimem_b = 1'b0;
    check("t5_error",      monitor_error, 32'h1);
    repeat (3) step();
    check("t5_areg",       dbg_mon_areg, 32'h32);
    cpu_xfer(1'b0, 9'h031, 32'h0, rd);
    check("t5_ram_31",     rd, 32'hBB);
    cpu_xfer(1'b0, 9'h032, 32'h0, rd);
    check("t5_ram_32",     rd, 32'h22);

    // 6. reset in the middle of a debug write
    pulse(2, jdo_data(32'h77));
    step();
    check("t6_state_acc",  dbg_state, DBG_ACC);
    reset_n = 1'b0;
    #1;
    check("t6_mondreg",    mon_dreg, 32'h0);
    check("t6_readdata",   avs.avs_readdata, 32'h0);
    check("t6_status",     {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
    check("t6_state",      dbg_state, IDLE);
    check("t6_pending",    dbg_pending, 32'h0);
    check("t6_areg",       dbg_mon_areg, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    cpu_xfer(1'b0, 9'h032, 32'h0, rd);
    check("t6_write_abort", rd, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
